// File: rtl/dmem_atomic_responder.sv
// -----------------------------------------------------------------------------
// dmem_atomic_responder
//
// Data-side memory responder. Accepts the datapath's dREN/dWEN/atomic
// requests, drives a single RAM port, and owns the LL/SC link register.
// An SC is resolved at acceptance: a valid link whose word address matches
// proceeds to a RAM write and returns dload=1, anything else fails without
// touching RAM and returns dload=0. Remote stores seen on the snoop port
// break a matching link.
//
// Ports
//   CLK, nRST             clock, asynchronous active-low reset
//   dREN, dWEN, atomic    request lines (LW/LL/SW/SC), held until dhit
//   daddr, dstore         byte address and store data of the request
//   dhit, dload, err      one-cycle completion pulse, load/SC result, timeout
//   ram_ren, ram_wen      RAM strobes, held until ram_ready or timeout
//   ram_addr, ram_store   latched request address and data
//   ram_load, ram_ready   RAM read data and completion
//   snoop_valid/addr      remote write address to check against the link
//   link_valid/addr       LL/SC link register (word aligned)
//
// Parameter
//   TIMEOUT               ACCESS cycles to wait for ram_ready before err
// -----------------------------------------------------------------------------
module dmem_atomic_responder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        atomic,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        err,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    input  logic        snoop_valid,
    input  logic [31:0] snoop_addr,
    output logic        link_valid,
    output logic [31:0] link_addr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_SCFAIL = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The counter only needs to reach TIMEOUT-1: the cycle that would make
    // it TIMEOUT is the one that aborts.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_reg,       state_next;
    logic          dhit_reg,        dhit_next;
    logic          err_reg,         err_next;
    logic [31:0]   dload_reg,       dload_next;
    logic          ram_ren_reg,     ram_ren_next;
    logic          ram_wen_reg,     ram_wen_next;
    logic [31:0]   ram_addr_reg,    ram_addr_next;
    logic [31:0]   ram_store_reg,   ram_store_next;
    logic          req_wr_reg,      req_wr_next;
    logic          req_atomic_reg,  req_atomic_next;
    logic          link_valid_reg,  link_valid_next;
    logic [31:0]   link_addr_reg,   link_addr_next;
    logic [CW-1:0] timeout_cnt_reg, timeout_cnt_next;

    logic req_seen;
    logic snoop_hit_link;
    logic sc_link_ok;
    logic ll_done;
    logic accept_clear;
    logic snoop_byte_unused;

    // Link matching works on word addresses; the snoop byte offset is ignored.
    assign snoop_byte_unused = ^snoop_addr[1:0];

    assign req_seen       = dREN | dWEN;
    assign snoop_hit_link = snoop_valid && link_valid_reg &&
                            (snoop_addr[31:2] == link_addr_reg[31:2]);
    // A snoop hitting the link in the acceptance cycle beats the SC.
    assign sc_link_ok     = link_valid_reg && !snoop_hit_link &&
                            (link_addr_reg[31:2] == daddr[31:2]);
    assign ll_done        = (state_reg == ST_ACCESS) && ram_ready &&
                            !req_wr_reg && req_atomic_reg;
    // Any accepted SC consumes the link; a plain SW only breaks a matching one.
    assign accept_clear   = (state_reg == ST_IDLE) && req_seen && dWEN &&
                            (atomic || (daddr[31:2] == link_addr_reg[31:2]));

    always_comb begin
        state_next       = state_reg;
        dhit_next        = 1'b0;
        err_next         = 1'b0;
        dload_next       = dload_reg;
        ram_ren_next     = ram_ren_reg;
        ram_wen_next     = ram_wen_reg;
        ram_addr_next    = ram_addr_reg;
        ram_store_next   = ram_store_reg;
        req_wr_next      = req_wr_reg;
        req_atomic_next  = req_atomic_reg;
        timeout_cnt_next = timeout_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_seen) begin
                    ram_addr_next    = daddr;
                    ram_store_next   = dstore;
                    req_wr_next      = dWEN;   // write wins when both are set
                    req_atomic_next  = atomic;
                    timeout_cnt_next = '0;
                    if (dWEN && atomic && !sc_link_ok) begin
                        state_next = ST_SCFAIL;
                    end else begin
                        state_next   = ST_ACCESS;
                        ram_ren_next = !dWEN;
                        ram_wen_next = dWEN;
                    end
                end
            end
            ST_ACCESS: begin
                if (ram_ready) begin
                    ram_ren_next = 1'b0;
                    ram_wen_next = 1'b0;
                    dhit_next    = 1'b1;
                    state_next   = ST_DONE;
                    if (!req_wr_reg) begin
                        dload_next = ram_load;
                    end else if (req_atomic_reg) begin
                        dload_next = 32'd1;
                    end else begin
                        dload_next = 32'd0;
                    end
                end else if (timeout_cnt_reg == CNT_LAST) begin
                    ram_ren_next = 1'b0;
                    ram_wen_next = 1'b0;
                    dhit_next    = 1'b1;
                    err_next     = 1'b1;
                    dload_next   = 32'hBAD1_BAD1;
                    state_next   = ST_DONE;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + CW'(1);
                end
            end
            ST_SCFAIL: begin
                dload_next = 32'd0;
                dhit_next  = 1'b1;
                state_next = ST_DONE;
            end
            default: begin
                // DONE: dhit/err are visible this cycle; requests are ignored.
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        link_valid_next = link_valid_reg;
        link_addr_next  = link_addr_reg;
        if (ll_done) begin
            // A new LL replaces the old link, but a snoop to the very word
            // being linked in the same cycle leaves it invalid.
            link_addr_next  = {ram_addr_reg[31:2], 2'b00};
            link_valid_next = !(snoop_valid &&
                                (snoop_addr[31:2] == ram_addr_reg[31:2]));
        end else if (snoop_hit_link || accept_clear) begin
            link_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg       <= ST_IDLE;
            dhit_reg        <= 1'b0;
            err_reg         <= 1'b0;
            dload_reg       <= 32'd0;
            ram_ren_reg     <= 1'b0;
            ram_wen_reg     <= 1'b0;
            ram_addr_reg    <= 32'd0;
            ram_store_reg   <= 32'd0;
            req_wr_reg      <= 1'b0;
            req_atomic_reg  <= 1'b0;
            link_valid_reg  <= 1'b0;
            link_addr_reg   <= 32'd0;
            timeout_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            dhit_reg        <= dhit_next;
            err_reg         <= err_next;
            dload_reg       <= dload_next;
            ram_ren_reg     <= ram_ren_next;
            ram_wen_reg     <= ram_wen_next;
            ram_addr_reg    <= ram_addr_next;
            ram_store_reg   <= ram_store_next;
            req_wr_reg      <= req_wr_next;
            req_atomic_reg  <= req_atomic_next;
            link_valid_reg  <= link_valid_next;
            link_addr_reg   <= link_addr_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    assign dhit       = dhit_reg;
    assign err        = err_reg;
    assign dload      = dload_reg;
    assign ram_ren    = ram_ren_reg;
    assign ram_wen    = ram_wen_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_store  = ram_store_reg;
    assign link_valid = link_valid_reg;
    assign link_addr  = link_addr_reg;

endmodule

// File: tb/tb_dmem_atomic_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_atomic_responder
//
// Directed scenarios followed by randomized LW/LL/SW/SC traffic with random
// RAM latency and random snoops. A transaction-level model of the link
// register predicts SC outcomes, load data and link state; the RAM side is
// played by the bench itself.
// -----------------------------------------------------------------------------
module tb_dmem_atomic_responder;

    localparam int TMO = 4;

    logic        CLK;
    logic        nRST;
    logic        dREN;
    logic        dWEN;
    logic        atomic;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        err;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        link_valid;
    logic [31:0] link_addr;

    dmem_atomic_responder #(.TIMEOUT(TMO)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .atomic     (atomic),
        .daddr      (daddr),
        .dstore     (dstore),
        .dhit       (dhit),
        .dload      (dload),
        .err        (err),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_store  (ram_store),
        .ram_load   (ram_load),
        .ram_ready  (ram_ready),
        .snoop_valid(snoop_valid),
        .snoop_addr (snoop_addr),
        .link_valid (link_valid),
        .link_addr  (link_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference link register.
    bit          lv_m;
    logic [31:0] la_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_link(input string tag);
        chk({tag, ".link_valid"}, {31'd0, link_valid}, {31'd0, lv_m});
        chk({tag, ".link_addr"}, link_addr, la_m);
    endtask

    // Apply this cycle's snoop to the model link.
    task automatic model_snoop();
        if (snoop_valid && lv_m && (snoop_addr[31:2] == la_m[31:2])) lv_m = 1'b0;
    endtask

    task automatic rand_snoop(input logic [31:0] near);
        int r;
        snoop_valid = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 2);
        if (r == 0)      snoop_addr = {la_m[31:2], 2'($urandom)};
        else if (r == 1) snoop_addr = {near[31:2], 2'($urandom)};
        else             snoop_addr = 32'h0000_0400 + {28'd0, 4'($urandom)};
    endtask

    task automatic idle_cycle(input bit sv, input logic [31:0] sa);
        snoop_valid = sv;
        snoop_addr  = sa;
        model_snoop();
        @(posedge CLK);
        @(negedge CLK);
        snoop_valid = 1'b0;
        chk("idle.dhit", {31'd0, dhit}, 32'd0);
        chk_link("idle");
    endtask

    // One complete request starting at a negedge with the DUT in IDLE.
    // k: cycle of ACCESS (1-based) in which ram_ready arrives; k > TMO never.
    task automatic txn(input bit wr, input bit at, input logic [31:0] addr,
                       input logic [31:0] data, input int k,
                       input logic [31:0] load_v, input bit rnd);
        bit          sc;
        bit          sc_ok;
        bit          done;
        int          i;
        logic [31:0] exp_load;
        bit          exp_err;
        string       kind;

        kind = wr ? (at ? "SC" : "SW") : (at ? "LL" : "LW");
        dWEN   = wr;
        dREN   = !wr || (rnd && ($urandom_range(0, 3) == 0));
        atomic = at;
        daddr  = addr;
        dstore = data;
        if (rnd) rand_snoop(addr);
        else     snoop_valid = 1'b0;

        // Acceptance: snoop first (it wins over an SC), then SC/SW effects.
        model_snoop();
        sc    = wr && at;
        sc_ok = sc && lv_m && (la_m[31:2] == addr[31:2]);
        if (wr && (at || (addr[31:2] == la_m[31:2]))) lv_m = 1'b0;
        @(posedge CLK);
        @(negedge CLK);

        exp_load = 32'd0;
        exp_err  = 1'b0;
        if (sc && !sc_ok) begin
            chk("scfail.ram_ren", {31'd0, ram_ren}, 32'd0);
            chk("scfail.ram_wen", {31'd0, ram_wen}, 32'd0);
            chk("scfail.dhit", {31'd0, dhit}, 32'd0);
            chk_link("scfail");
            if (rnd) rand_snoop(addr);
            else     snoop_valid = 1'b0;
            model_snoop();
            @(posedge CLK);
            @(negedge CLK);
        end else begin
            done = 1'b0;
            i = 1;
            while (!done) begin
                chk("access.ram_ren", {31'd0, ram_ren}, {31'd0, !wr});
                chk("access.ram_wen", {31'd0, ram_wen}, {31'd0, wr});
                chk("access.ram_addr", ram_addr, addr);
                chk("access.ram_store", ram_store, data);
                chk("access.dhit", {31'd0, dhit}, 32'd0);
                chk_link("access");
                ram_ready = (i == k);
                ram_load  = (i == k) ? load_v : $urandom;
                if (rnd) rand_snoop(addr);
                else     snoop_valid = 1'b0;
                if (i == k && !wr && at) begin
                    lv_m = 1'b1;
                    la_m = {addr[31:2], 2'b00};
                end
                model_snoop();
                @(posedge CLK);
                @(negedge CLK);
                if (i == k) begin
                    exp_load = wr ? (at ? 32'd1 : 32'd0) : load_v;
                    done = 1'b1;
                end else if (i == TMO) begin
                    exp_load = 32'hBAD1_BAD1;
                    exp_err  = 1'b1;
                    done = 1'b1;
                end
                i++;
            end
        end

        ram_ready   = 1'b0;
        snoop_valid = 1'b0;
        chk({kind, ".dhit"}, {31'd0, dhit}, 32'd1);
        chk({kind, ".err"}, {31'd0, err}, {31'd0, exp_err});
        chk({kind, ".dload"}, dload, exp_load);
        chk({kind, ".done_ren"}, {31'd0, ram_ren}, 32'd0);
        chk({kind, ".done_wen"}, {31'd0, ram_wen}, 32'd0);
        chk_link(kind);
        n_txn++;
        $display("txn %0d: %s addr=%h dload=%h err=%0b link_valid=%0b",
                 n_txn, kind, addr, dload, err, link_valid);

        dREN   = 1'b0;
        dWEN   = 1'b0;
        atomic = 1'b0;
        if (rnd) rand_snoop(addr);
        model_snoop();
        @(posedge CLK);
        @(negedge CLK);
        snoop_valid = 1'b0;
        chk("after.dhit", {31'd0, dhit}, 32'd0);
        chk("after.err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        nRST = 1'b1; dREN = 1'b0; dWEN = 1'b0; atomic = 1'b0;
        daddr = 32'd0; dstore = 32'd0; ram_load = 32'd0; ram_ready = 1'b0;
        snoop_valid = 1'b0; snoop_addr = 32'd0;
        lv_m = 1'b0; la_m = 32'd0;

        // Reset values
        #2 nRST = 1'b0;
        #1;
        chk("rst.dhit", {31'd0, dhit}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        chk("rst.dload", dload, 32'd0);
        chk("rst.ram_ren", {31'd0, ram_ren}, 32'd0);
        chk("rst.ram_wen", {31'd0, ram_wen}, 32'd0);
        chk("rst.ram_addr", ram_addr, 32'd0);
        chk("rst.ram_store", ram_store, 32'd0);
        chk_link("rst");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);

        // LW with ram_ready in the third strobe cycle
        txn(1'b0, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        // LL then successful SC
        txn(1'b0, 1'b1, 32'h200, 32'h0, 1, 32'h1234_5678, 1'b0);
        chk("ll.link_valid", {31'd0, link_valid}, 32'd1);
        chk("ll.link_addr", link_addr, 32'h200);
        txn(1'b1, 1'b1, 32'h200, 32'h55, 2, 32'h0, 1'b0);
        chk("sc_ok.link_valid", {31'd0, link_valid}, 32'd0);
        // LL, snoop to same word, SC fails
        txn(1'b0, 1'b1, 32'h200, 32'h0, 2, 32'hCAFE_0001, 1'b0);
        idle_cycle(1'b1, 32'h202);
        chk("snoop.link_valid", {31'd0, link_valid}, 32'd0);
        txn(1'b1, 1'b1, 32'h200, 32'h77, 1, 32'h0, 1'b0);
        // LL then SC to another word, then SC to the linked word
        txn(1'b0, 1'b1, 32'h200, 32'h0, 1, 32'hCAFE_0002, 1'b0);
        txn(1'b1, 1'b1, 32'h300, 32'h88, 1, 32'h0, 1'b0);
        txn(1'b1, 1'b1, 32'h200, 32'h99, 1, 32'h0, 1'b0);
        // Plain SW and a timed-out LW
        txn(1'b1, 1'b0, 32'h104, 32'hA5A5_A5A5, 2, 32'h0, 1'b0);
        txn(1'b0, 1'b0, 32'h108, 32'h0, 100, 32'h0, 1'b0);
        // Timed-out LL leaves no link
        txn(1'b0, 1'b1, 32'h20C, 32'h0, 100, 32'h0, 1'b0);

        // Reset during ACCESS of an LL, after an earlier LL set the link
        txn(1'b0, 1'b1, 32'h300, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
        dREN = 1'b1; atomic = 1'b1; daddr = 32'h200;
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid.ram_ren_before", {31'd0, ram_ren}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        lv_m = 1'b0; la_m = 32'd0;
        chk("rstmid.ram_ren", {31'd0, ram_ren}, 32'd0);
        chk("rstmid.dhit", {31'd0, dhit}, 32'd0);
        chk("rstmid.ram_addr", ram_addr, 32'd0);
        chk_link("rstmid");
        dREN = 1'b0; atomic = 1'b0;
        ram_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        ram_ready = 1'b0;
        nRST = 1'b1;
        chk("rstmid.dhit_hold", {31'd0, dhit}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid.dhit_after", {31'd0, dhit}, 32'd0);
        chk_link("rstmid_after");
        txn(1'b0, 1'b0, 32'h110, 32'h0, 1, 32'h1357_9BDF, 1'b0);

        // Randomized traffic on a small set of words so links get hit
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int          ty;
            a  = 32'h200 + {26'd0, 2'($urandom), 2'd0, 2'($urandom)};
            ty = $urandom_range(0, 3);
            txn(ty[1], ty[0], a, $urandom, $urandom_range(1, TMO + 2), $urandom, 1'b1);
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                logic [31:0] sa;
                sa = {la_m[31:2], 2'($urandom)};
                idle_cycle($urandom_range(0, 2) == 0, sa);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_atomic_responder.md
# dmem_atomic_responder

Data-side memory responder that answers the datapath's dREN/dWEN/atomic requests and drives a RAM port. It holds the LL/SC link register, so it resolves store-conditional success or failure and returns the SC result on dload. It sits between the datapath's data request lines and the RAM/bus arbiter, on the opposite end of the request protocol the decoder generates. It also snoops remote stores so that another core's write breaks the link.

## Interface
- TIMEOUT, 255: maximum ACCESS cycles to wait for ram_ready before aborting with err.
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- dREN  in  1  read request (LW, LL); held until dhit.
- dWEN  in  1  write request (SW, SC); held until dhit.
- atomic  in  1  qualifies a request: with dREN it is LL, with dWEN it is SC.
- daddr  in  32  byte address; compared as word address daddr[31:2].
- dstore  in  32  store data.
- dhit  out  1  one-cycle completion pulse.
- dload  out  32  load data (LW/LL), or the SC result (1 = success, 0 = fail); valid while dhit=1.
- err  out  1  one-cycle pulse, coincident with dhit, when an access times out.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  32  RAM address (latched daddr).
- ram_store  out  32  RAM write data (latched dstore).
- ram_load  in  32  RAM read data; valid with ram_ready.
- ram_ready  in  1  RAM completion.
- snoop_valid  in  1  a remote core is writing snoop_addr this cycle.
- snoop_addr  in  32  remote write address.
- link_valid  out  1  link register valid.
- link_addr  out  32  linked address, word aligned, [1:0]=0.

## Operation
- The FSM has four states: IDLE, ACCESS, SCFAIL and DONE.
- IDLE: when dREN or dWEN is seen, latch the request (addr, data, type, atomic). If dREN and dWEN are both set, treat the request as a write.
- IDLE transitions:
  - SC with link_valid=0, or with link_addr[31:2] != daddr[31:2]: go to SCFAIL.
  - Any other request: go to ACCESS.
- ACCESS:
  - Assert ram_ren or ram_wen, plus ram_addr/ram_store, every cycle until ram_ready.
  - On ram_ready, capture ram_load (reads) or 32'd1 (SC) into dload and go to DONE.
  - A plain SW completes with dload = 32'd0.
- Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle without ram_ready. When it reaches TIMEOUT, drop the strobes, set dload = 32'hBAD1BAD1, set the error flag and go to DONE.
- SCFAIL: no RAM strobe; load dload = 32'd0 and go to DONE.
- DONE: dhit=1 (and err if flagged) for exactly one cycle, then return to IDLE. A request is not accepted in DONE.
- Link register rules, in priority order per cycle:
  1. Reset clears it.
  2. Set: an LL completion (ram_ready in ACCESS) sets link_valid=1 and link_addr={addr[31:2],2'b00}. This overrides any earlier link.
  3. Clear: any of the following clears link_valid:
     - snoop_valid with snoop_addr[31:2] matching link_addr[31:2];
     - acceptance in IDLE of a local SW or SC whose word address matches;
     - acceptance of any SC, whether it succeeds or fails.
- Simultaneous events:
  - If a snoop invalidation and an SC acceptance occur in the same IDLE cycle, the snoop wins and the SC fails.
  - If an LL completion and a matching snoop occur in the same cycle, the link ends invalid.
- A snoop during SC ACCESS does not revoke an SC already committed to ACCESS.
- A timed-out LL does not set the link.

## Timing
- Reset values: state=IDLE, dhit=0, err=0, dload=0, ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0, link_valid=0, link_addr=0, timeout counter=0.
- All outputs are registered. Reset mid-transaction returns to IDLE immediately, drops the strobes and clears the link; no dhit is issued.
- Read/write latency:
  - Request seen in cycle t.
  - Strobes asserted in cycles t+1 .. t+k, where ram_ready arrives in cycle t+k.
  - dhit in cycle t+k+1.
  - Minimum: dhit at t+2.
- SC fail latency: SCFAIL at t+1, dhit at t+2.
- Timeout latency: dhit at t+TIMEOUT+1.
- Back-to-back requests: the next request can be accepted in the cycle after dhit, i.e. the datapath's next request is sampled in IDLE.
- Handshake: the datapath must hold its request through dhit. The responder acts only on the values latched at acceptance, so changes to the request after acceptance are ignored.

## Test plan
- LW 0x100 with ram_ready 3 cycles after the strobe and ram_load=0xDEADBEEF: ram_ren is high for 3 cycles; dhit in the cycle after ram_ready with dload=0xDEADBEEF; err=0.
- LL 0x200, then SC 0x200 with dstore=0x55: link_valid=1 with link_addr=0x200 after the LL; the SC issues ram_wen with ram_store=0x55, then dhit with dload=1 and link_valid=0.
- LL 0x200; snoop_valid with snoop_addr=0x202; then SC 0x200: link cleared on the snoop cycle; the SC produces no ram_wen, dhit 2 cycles after the request, dload=0.
- LL 0x200, then SC 0x300: SC fails (dload=0), no RAM write, link_valid=0. A following SC 0x200 also fails.
- LW with ram_ready never asserted, TIMEOUT=4: strobe held for 4 cycles, then dhit=1, err=1, dload=0xBAD1BAD1, back in IDLE.
- Assert nRST=0 during ACCESS of an LL: outputs return to reset values immediately, no dhit, link_valid=0; a fresh LW after reset completes normally.
